// File: rtl/pl_stage_hs.sv
`default_nettype none
// ============================================================================
// Module   : pl_stage_hs
// Brief    : Generic pipeline stage register with valid/ready handshake.
//            SKID=1 gives a 2-entry skid buffer with a registered in_ready,
//            so there is no combinational out_ready -> in_ready path.
//            SKID=0 gives a single register with a combinational in_ready.
//            Synchronous flush clears every entry. Empty slots hold
//            BUBBLE_VAL so out_data never shows stale data.
// Revision : 1.0 - initial release
// ============================================================================
module pl_stage_hs #(
    parameter int                 DATA_W     = 160,
    parameter int                 SKID       = 1,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic w_in_fire;
    logic w_out_fire;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            typedef enum logic [1:0] {
                ST_EMPTY = 2'd0,
                ST_ONE   = 2'd1,
                ST_TWO   = 2'd2
            } state_t;

            state_t            r_state;
            state_t            w_state_nxt;
            logic [DATA_W-1:0] r_main;
            logic [DATA_W-1:0] r_skid;
            logic [DATA_W-1:0] w_main_nxt;
            logic [DATA_W-1:0] w_skid_nxt;
            logic              r_in_ready;

            // Next-state and next-data decode; flush overrides every transfer.
            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                if (flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                    w_skid_nxt  = BUBBLE_VAL;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                w_state_nxt = ST_ONE;
                                w_main_nxt  = in_data;
                            end
                        end
                        ST_ONE: begin
                            if (w_in_fire && w_out_fire) begin
                                w_main_nxt  = in_data;
                            end else if (w_in_fire) begin
                                w_state_nxt = ST_TWO;
                                w_skid_nxt  = in_data;
                            end else if (w_out_fire) begin
                                w_state_nxt = ST_EMPTY;
                                w_main_nxt  = BUBBLE_VAL;
                            end
                        end
                        ST_TWO: begin
                            if (w_out_fire) begin
                                w_state_nxt = ST_ONE;
                                w_main_nxt  = r_skid;
                                w_skid_nxt  = BUBBLE_VAL;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_EMPTY;
                            w_main_nxt  = BUBBLE_VAL;
                            w_skid_nxt  = BUBBLE_VAL;
                        end
                    endcase
                end
            end

            // State/data registers; in_ready is precomputed from the next state.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state    <= ST_EMPTY;
                    r_main     <= BUBBLE_VAL;
                    r_skid     <= BUBBLE_VAL;
                    r_in_ready <= 1'b1;
                end else begin
                    r_state    <= w_state_nxt;
                    r_main     <= w_main_nxt;
                    r_skid     <= w_skid_nxt;
                    r_in_ready <= (w_state_nxt != ST_TWO);
                end
            end

            assign in_ready  = r_in_ready;
            assign out_valid = (r_state != ST_EMPTY);
            assign out_data  = r_main;
            assign occupancy = r_state;
        end else begin : g_noskid
            logic              r_valid;
            logic [DATA_W-1:0] r_main;

            // Single-entry register: flush, then load, then drain.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_main  <= BUBBLE_VAL;
                end else if (flush) begin
                    r_valid <= 1'b0;
                    r_main  <= BUBBLE_VAL;
                end else if (w_in_fire) begin
                    r_valid <= 1'b1;
                    r_main  <= in_data;
                end else if (w_out_fire) begin
                    r_valid <= 1'b0;
                    r_main  <= BUBBLE_VAL;
                end
            end

            assign in_ready  = ~r_valid | out_ready;
            assign out_valid = r_valid;
            assign out_data  = r_main;
            assign occupancy = {1'b0, r_valid};
        end
    endgenerate

endmodule
`default_nettype wire
